// File: rtl/lsu_16b.sv
// Load/store unit: runs each scheduler request as one or two little-endian byte
// cycles on an 8-bit bus and returns the assembled read data with a done strobe.
module lsu_16b #(
    parameter bit PAGE_WRAP = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] lsu_adr,
    input  logic [15:0] lsu_payload,
    input  logic        sched_req,
    input  logic        sched_we,
    input  logic        sched_wide,
    input  logic        sched_abort,
    output logic        lsu_ready,
    output logic        lsu_done,
    output logic [15:0] lsu_rdata,
    output logic [15:0] mem_adr,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] adr_q;
    logic [15:0] payload_q;
    logic        we_q;
    logic        wide_q;
    logic [15:0] rdata_q;
    logic [15:0] adr_hi;
    logic        byte_done;

    // Page-wrap mode keeps the high byte inside the same 256-byte page.
    assign adr_hi = PAGE_WRAP ? {adr_q[15:8], adr_q[7:0] + 8'd1} : adr_q + 16'd1;

    // A bus cycle only counts when it is not cancelled in the same clock.
    assign byte_done = mem_ready && !sched_abort;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            adr_q     <= 16'd0;
            payload_q <= 16'd0;
            we_q      <= 1'b0;
            wide_q    <= 1'b0;
            rdata_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && sched_req) begin
                adr_q     <= lsu_adr;
                payload_q <= lsu_payload;
                we_q      <= sched_we;
                wide_q    <= sched_wide;
                rdata_q   <= 16'd0;
            end
            if (state_q == LO && byte_done && !we_q) begin
                rdata_q[7:0] <= mem_din;
            end
            if (state_q == HI && byte_done && !we_q) begin
                rdata_q[15:8] <= mem_din;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        lsu_ready = 1'b0;
        lsu_done  = 1'b0;
        lsu_rdata = 16'd0;
        mem_adr   = 16'd0;
        mem_dout  = 8'd0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        case (state_q)
            IDLE: begin
                lsu_ready = 1'b1;
                if (sched_req) begin
                    state_d = LO;
                end
            end
            LO: begin
                mem_adr  = adr_q;
                mem_dout = payload_q[7:0];
                mem_rd   = !we_q;
                mem_wr   = we_q;
                if (sched_abort) begin
                    state_d = IDLE;
                end else if (mem_ready) begin
                    state_d = wide_q ? HI : DONE;
                end
            end
            HI: begin
                mem_adr  = adr_hi;
                mem_dout = payload_q[15:8];
                mem_rd   = !we_q;
                mem_wr   = we_q;
                if (sched_abort) begin
                    state_d = IDLE;
                end else if (mem_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                lsu_done  = 1'b1;
                lsu_rdata = we_q ? 16'd0 : rdata_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_16b.sv
// Directed bench for lsu_16b with a byte-array memory model; a second instance
// with page wrapping covers the high-byte address variant.
module tb_lsu_16b;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] lsu_adr;
    logic [15:0] lsu_payload;
    logic        sched_req;
    logic        sched_req2;
    logic        sched_we;
    logic        sched_wide;
    logic        sched_abort;
    logic        mem_ready;

    logic        lsu_ready, lsu_done, mem_rd, mem_wr;
    logic [15:0] lsu_rdata, mem_adr;
    logic [7:0]  mem_dout, mem_din;

    logic        lsu_ready2, lsu_done2, mem_rd2, mem_wr2;
    logic [15:0] lsu_rdata2, mem_adr2;
    logic [7:0]  mem_dout2, mem_din2;

    logic [7:0]  mem_arr [0:65535];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu_16b #(.PAGE_WRAP(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .lsu_adr(lsu_adr), .lsu_payload(lsu_payload),
        .sched_req(sched_req), .sched_we(sched_we), .sched_wide(sched_wide),
        .sched_abort(sched_abort), .lsu_ready(lsu_ready), .lsu_done(lsu_done),
        .lsu_rdata(lsu_rdata), .mem_adr(mem_adr), .mem_dout(mem_dout),
        .mem_din(mem_din), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ready(mem_ready)
    );

    lsu_16b #(.PAGE_WRAP(1'b1)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .lsu_adr(lsu_adr), .lsu_payload(lsu_payload),
        .sched_req(sched_req2), .sched_we(sched_we), .sched_wide(sched_wide),
        .sched_abort(sched_abort), .lsu_ready(lsu_ready2), .lsu_done(lsu_done2),
        .lsu_rdata(lsu_rdata2), .mem_adr(mem_adr2), .mem_dout(mem_dout2),
        .mem_din(mem_din2), .mem_rd(mem_rd2), .mem_wr(mem_wr2), .mem_ready(mem_ready)
    );

    assign mem_din  = mem_arr[mem_adr];
    assign mem_din2 = mem_arr[mem_adr2];

    always @(posedge clk) begin
        if (mem_wr && mem_ready) mem_arr[mem_adr] <= mem_dout;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        total++;
        if (lsu_ready !== 1'b1 || lsu_done !== 1'b0 || lsu_rdata !== 16'h0) begin
            bad++;
            $display("FAIL reset_lsu: ready=%b done=%b rdata=%h, want 1 0 0000", lsu_ready, lsu_done, lsu_rdata);
        end
        total++;
        if (mem_adr !== 16'h0 || mem_dout !== 8'h0 || mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
            bad++;
            $display("FAIL reset_bus: adr=%h dout=%h rd=%b wr=%b, want all 0", mem_adr, mem_dout, mem_rd, mem_wr);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_narrow_load();
        mem_arr[16'h1234] = 8'hA5;
        lsu_adr = 16'h1234; sched_we = 1'b0; sched_wide = 1'b0; sched_req = 1'b1;
        step();
        sched_req = 1'b0;
        total++;
        if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_adr !== 16'h1234 || lsu_done !== 1'b0 || lsu_ready !== 1'b0) begin
            bad++;
            $display("FAIL narrow_lo: rd=%b wr=%b adr=%h done=%b ready=%b, want 1 0 1234 0 0", mem_rd, mem_wr, mem_adr, lsu_done, lsu_ready);
        end
        step();
        total++;
        if (lsu_done !== 1'b1 || lsu_rdata !== 16'h00A5 || mem_rd !== 1'b0 || mem_adr !== 16'h0) begin
            bad++;
            $display("FAIL narrow_done: done=%b rdata=%h rd=%b adr=%h, want 1 00a5 0 0000", lsu_done, lsu_rdata, mem_rd, mem_adr);
        end
        step();
        total++;
        if (lsu_done !== 1'b0 || lsu_ready !== 1'b1) begin
            bad++;
            $display("FAIL narrow_idle: done=%b ready=%b, want 0 1", lsu_done, lsu_ready);
        end
    endtask

    task automatic test_wide_store();
        lsu_adr = 16'h2000; lsu_payload = 16'hBEEF; sched_we = 1'b1; sched_wide = 1'b1; sched_req = 1'b1;
        step();
        sched_req = 1'b0;
        total++;
        if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_adr !== 16'h2000 || mem_dout !== 8'hEF) begin
            bad++;
            $display("FAIL store_lo: wr=%b rd=%b adr=%h dout=%h, want 1 0 2000 ef", mem_wr, mem_rd, mem_adr, mem_dout);
        end
        step();
        total++;
        if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_adr !== 16'h2001 || mem_dout !== 8'hBE || lsu_done !== 1'b0) begin
            bad++;
            $display("FAIL store_hi: wr=%b rd=%b adr=%h dout=%h done=%b, want 1 0 2001 be 0", mem_wr, mem_rd, mem_adr, mem_dout, lsu_done);
        end
        step();
        total++;
        if (lsu_done !== 1'b1 || lsu_rdata !== 16'h0 || mem_wr !== 1'b0 || mem_rd !== 1'b0) begin
            bad++;
            $display("FAIL store_done: done=%b rdata=%h wr=%b rd=%b, want 1 0000 0 0", lsu_done, lsu_rdata, mem_wr, mem_rd);
        end
        total++;
        if (mem_arr[16'h2000] !== 8'hEF || mem_arr[16'h2001] !== 8'hBE) begin
            bad++;
            $display("FAIL store_mem: got %h %h, want ef be", mem_arr[16'h2000], mem_arr[16'h2001]);
        end
        step();
    endtask

    task automatic test_wrap();
        mem_arr[16'hFFFF] = 8'h11; mem_arr[16'h0000] = 8'h22;
        lsu_adr = 16'hFFFF; sched_we = 1'b0; sched_wide = 1'b1; sched_req = 1'b1;
        step();
        sched_req = 1'b0;
        step();
        total++;
        if (mem_adr !== 16'h0000 || mem_rd !== 1'b1) begin
            bad++;
            $display("FAIL wrap_full_adr: adr=%h rd=%b, want 0000 1", mem_adr, mem_rd);
        end
        step();
        total++;
        if (lsu_done !== 1'b1 || lsu_rdata !== 16'h2211) begin
            bad++;
            $display("FAIL wrap_full_data: done=%b rdata=%h, want 1 2211", lsu_done, lsu_rdata);
        end
        step();
        mem_arr[16'h12FF] = 8'h11; mem_arr[16'h1200] = 8'h22; mem_arr[16'h1300] = 8'h99;
        lsu_adr = 16'h12FF; sched_req2 = 1'b1;
        step();
        sched_req2 = 1'b0;
        step();
        total++;
        if (mem_adr2 !== 16'h1200 || mem_rd2 !== 1'b1) begin
            bad++;
            $display("FAIL wrap_page_adr: adr=%h rd=%b, want 1200 1", mem_adr2, mem_rd2);
        end
        step();
        total++;
        if (lsu_done2 !== 1'b1 || lsu_rdata2 !== 16'h2211) begin
            bad++;
            $display("FAIL wrap_page_data: done=%b rdata=%h, want 1 2211", lsu_done2, lsu_rdata2);
        end
        step();
    endtask

    task automatic test_wait_states();
        logic [4:0] ready_seq;
        int edges;
        bit seen;
        bit stable_ok;
        ready_seq = 5'b10100;  // applied LSB first: 0,0,1,0,1
        mem_arr[16'h3000] = 8'h34; mem_arr[16'h3001] = 8'h12;
        lsu_adr = 16'h3000; sched_we = 1'b0; sched_wide = 1'b1; sched_req = 1'b1;
        step();
        sched_req = 1'b0;
        edges = 1; seen = 1'b0; stable_ok = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            mem_ready = (i < 5) ? ready_seq[i] : 1'b1;
            if (i == 1 && (mem_adr !== 16'h3000 || mem_rd !== 1'b1 || mem_wr !== 1'b0)) stable_ok = 1'b0;
            if (i == 2 && (mem_adr !== 16'h3000 || mem_rd !== 1'b1)) stable_ok = 1'b0;
            if (i == 4 && (mem_adr !== 16'h3001 || mem_rd !== 1'b1)) stable_ok = 1'b0;
            step();
            edges++;
            if (lsu_done === 1'b1) seen = 1'b1;
        end
        mem_ready = 1'b1;
        total++;
        if (!stable_ok) begin
            bad++;
            $display("FAIL wait_stable: bus outputs changed while waiting");
        end
        total++;
        if (!seen || edges !== 6 || lsu_rdata !== 16'h1234) begin
            bad++;
            $display("FAIL wait_latency: seen=%b edges=%0d rdata=%h, want 1 6 1234", seen, edges, lsu_rdata);
        end
        step();
    endtask

    task automatic test_abort();
        lsu_adr = 16'h4000; sched_we = 1'b0; sched_wide = 1'b1; sched_req = 1'b1;
        step();
        sched_req = 1'b0;
        step();
        sched_abort = 1'b1;
        step();
        sched_abort = 1'b0;
        total++;
        if (lsu_ready !== 1'b1 || lsu_done !== 1'b0 || mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
            bad++;
            $display("FAIL abort_hi: ready=%b done=%b rd=%b wr=%b, want 1 0 0 0", lsu_ready, lsu_done, mem_rd, mem_wr);
        end
        step();
        total++;
        if (lsu_done !== 1'b0 || lsu_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_nodone: done=%b ready=%b, want 0 1", lsu_done, lsu_ready);
        end
        sched_abort = 1'b1;
        step();
        total++;
        if (lsu_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_idle: ready=%b, want 1", lsu_ready);
        end
        lsu_adr = 16'h1234; sched_wide = 1'b0; sched_req = 1'b1;
        step();
        sched_req = 1'b0; sched_abort = 1'b0;
        step();
        total++;
        if (lsu_done !== 1'b1 || lsu_rdata !== 16'h00A5) begin
            bad++;
            $display("FAIL abort_accept: done=%b rdata=%h, want 1 00a5", lsu_done, lsu_rdata);
        end
        step();
    endtask

    task automatic test_reset_mid();
        lsu_adr = 16'h5000; lsu_payload = 16'h5566; sched_we = 1'b1; sched_wide = 1'b1; sched_req = 1'b1;
        step();
        sched_req = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        total++;
        if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || lsu_ready !== 1'b1 || lsu_done !== 1'b0 || lsu_rdata !== 16'h0 || mem_adr !== 16'h0) begin
            bad++;
            $display("FAIL reset_mid: rd=%b wr=%b ready=%b done=%b rdata=%h adr=%h", mem_rd, mem_wr, lsu_ready, lsu_done, lsu_rdata, mem_adr);
        end
        total++;
        if (mem_arr[16'h5000] !== 8'h66) begin
            bad++;
            $display("FAIL reset_mid_mem: got %h, want 66", mem_arr[16'h5000]);
        end
        lsu_adr = 16'h1234; sched_we = 1'b0; sched_wide = 1'b0; sched_req = 1'b1;
        step();
        sched_req = 1'b0;
        step();
        total++;
        if (lsu_done !== 1'b1 || lsu_rdata !== 16'h00A5) begin
            bad++;
            $display("FAIL reset_recover: done=%b rdata=%h, want 1 00a5", lsu_done, lsu_rdata);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int dones;
        dones = 0;
        lsu_adr = 16'h1234; sched_we = 1'b0; sched_wide = 1'b0; sched_req = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            if (lsu_done === 1'b1) dones++;
        end
        sched_req = 1'b0;
        total++;
        if (dones !== 3) begin
            bad++;
            $display("FAIL back_to_back: done pulses=%0d, want 3", dones);
        end
        step();
        step();
    endtask

    initial begin
        rst_n = 1'b0; lsu_adr = 16'h0; lsu_payload = 16'h0; sched_req = 1'b0; sched_req2 = 1'b0;
        sched_we = 1'b0; sched_wide = 1'b0; sched_abort = 1'b0; mem_ready = 1'b1;
        test_reset();
        test_narrow_load();
        test_wide_store();
        test_wrap();
        test_wait_states();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
